// File: rtl/bp_cce_hybrid_pending_writer_if.sv
// Request and pending-bits write bundle for bp_cce_hybrid_pending_writer.
// Master drives requests and observes the write port; slave is the writer.
interface bp_cce_hybrid_pending_writer_if #(
  parameter int paddr_width_p = 40
);
  logic                     inc_v_i;
  logic [paddr_width_p-1:0] inc_addr_i;
  logic                     inc_bypass_i;
  logic                     inc_ready_and_o;
  logic                     dec_v_i;
  logic [paddr_width_p-1:0] dec_addr_i;
  logic                     dec_bypass_i;
  logic                     dec_ready_and_o;
  logic                     w_v_o;
  logic [paddr_width_p-1:0] w_addr_o;
  logic                     w_addr_bypass_hash_o;
  logic                     up_o;
  logic                     down_o;
  logic                     clear_o;
  logic                     idle_o;

  modport master (
    output inc_v_i, inc_addr_i, inc_bypass_i, dec_v_i, dec_addr_i, dec_bypass_i,
    input  inc_ready_and_o, dec_ready_and_o, w_v_o, w_addr_o, w_addr_bypass_hash_o,
           up_o, down_o, clear_o, idle_o
  );

  modport slave (
    input  inc_v_i, inc_addr_i, inc_bypass_i, dec_v_i, dec_addr_i, dec_bypass_i,
    output inc_ready_and_o, dec_ready_and_o, w_v_o, w_addr_o, w_addr_bypass_hash_o,
           up_o, down_o, clear_o, idle_o
  );
endinterface

// File: rtl/bp_cce_hybrid_pending_writer.sv
// Merges pipeline increments and FIFO-buffered decrements onto one pending-bits write port.
// Optional BP_CCE_HYBRID_PENDING_CANCEL_EN: a matching increment and FIFO head cancel each other.
module bp_cce_hybrid_pending_writer #(
  parameter int paddr_width_p       = 40,
  parameter int dec_fifo_els_p      = 4,
  parameter int starve_limit_p      = 3,
  parameter int outstanding_width_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_cce_hybrid_pending_writer_if.slave bus
);
  localparam int ptr_w_lp    = (dec_fifo_els_p > 1) ? $clog2(dec_fifo_els_p) : 1;
  localparam int cnt_w_lp    = $clog2(dec_fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  localparam int entry_w_lp  = paddr_width_p + 1;

  typedef logic [entry_w_lp-1:0] entry_t;

  entry_t                         mem_q [dec_fifo_els_p];
  entry_t                         mem_d [dec_fifo_els_p];
  logic [ptr_w_lp-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]            count_q, count_d;
  logic [starve_w_lp-1:0]         starve_q, starve_d;
  logic [outstanding_width_p-1:0] outstanding_q, outstanding_d;
  logic                           idle_q, idle_d;

  entry_t head_s;
  logic   empty_s, full_s, force_s, cancel_s;
  logic   enq_s, deq_s, inc_take_s, w_inc_s, w_dec_s;

  // Grant arbitration between the incoming increment and the FIFO head
  always_comb begin
    head_s     = mem_q[rd_ptr_q];
    empty_s    = (count_q == {cnt_w_lp{1'b0}});
    full_s     = (count_q == cnt_w_lp'(dec_fifo_els_p));
    force_s    = bus.inc_v_i & (starve_q == starve_w_lp'(starve_limit_p));
    cancel_s   = 1'b0;
    inc_take_s = 1'b0;
    deq_s      = 1'b0;
    w_inc_s    = 1'b0;
    w_dec_s    = 1'b0;
`ifdef BP_CCE_HYBRID_PENDING_CANCEL_EN
    cancel_s   = bus.inc_v_i & ~empty_s & ({bus.inc_addr_i, bus.inc_bypass_i} == head_s);
`endif
    if (reset_i) begin
      inc_take_s = 1'b0;
    end else if (cancel_s) begin
      inc_take_s = 1'b1;
      deq_s      = 1'b1;
    end else if (force_s) begin
      inc_take_s = 1'b1;
      w_inc_s    = 1'b1;
    end else if (!empty_s) begin
      deq_s      = 1'b1;
      w_dec_s    = 1'b1;
    end else if (bus.inc_v_i) begin
      inc_take_s = 1'b1;
      w_inc_s    = 1'b1;
    end else begin
      inc_take_s = 1'b0;
    end
    enq_s = ~reset_i & bus.dec_v_i & ~full_s;
  end

  // FIFO, starve, outstanding and idle next-state
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq_s) begin
      mem_d[wr_ptr_q] = {bus.dec_addr_i, bus.dec_bypass_i};
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(dec_fifo_els_p - 1)) ? {ptr_w_lp{1'b0}}
                                                             : wr_ptr_q + ptr_w_lp'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(dec_fifo_els_p - 1)) ? {ptr_w_lp{1'b0}}
                                                             : rd_ptr_q + ptr_w_lp'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (enq_s && !deq_s) begin
      count_d = count_q + cnt_w_lp'(1);
    end else if (!enq_s && deq_s) begin
      count_d = count_q - cnt_w_lp'(1);
    end else begin
      count_d = count_q;
    end

    if (inc_take_s) begin
      starve_d = {starve_w_lp{1'b0}};
    end else if (bus.inc_v_i && (starve_q != starve_w_lp'(starve_limit_p))) begin
      starve_d = starve_q + starve_w_lp'(1);
    end else begin
      starve_d = starve_q;
    end

    // Wraps on purpose; the checker reports over/underflow in simulation
    if (w_inc_s) begin
      outstanding_d = outstanding_q + outstanding_width_p'(1);
    end else if (w_dec_s) begin
      outstanding_d = outstanding_q - outstanding_width_p'(1);
    end else begin
      outstanding_d = outstanding_q;
    end

    idle_d = (outstanding_d == {outstanding_width_p{1'b0}}) & (count_d == {cnt_w_lp{1'b0}});
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q      <= {ptr_w_lp{1'b0}};
      wr_ptr_q      <= {ptr_w_lp{1'b0}};
      count_q       <= {cnt_w_lp{1'b0}};
      starve_q      <= {starve_w_lp{1'b0}};
      outstanding_q <= {outstanding_width_p{1'b0}};
      idle_q        <= 1'b1;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
      outstanding_q <= outstanding_d;
      idle_q        <= idle_d;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.inc_ready_and_o      = inc_take_s;
  assign bus.dec_ready_and_o      = ~full_s;
  assign bus.w_v_o                = w_inc_s | w_dec_s;
  assign bus.w_addr_o             = w_dec_s ? head_s[entry_w_lp-1:1] : bus.inc_addr_i;
  assign bus.w_addr_bypass_hash_o = w_dec_s ? head_s[0] : bus.inc_bypass_i;
  assign bus.up_o                 = w_inc_s;
  assign bus.down_o               = w_dec_s;
  assign bus.clear_o              = 1'b0;
  assign bus.idle_o               = idle_q;

`ifndef SYNTHESIS
  bp_cce_hybrid_pending_writer_chk #(
    .outstanding_width_p(outstanding_width_p)
  ) chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .up_i         (w_inc_s),
    .down_i       (w_dec_s),
    .outstanding_i(outstanding_q)
  );
`endif
endmodule

module bp_cce_hybrid_pending_writer_chk #(
  parameter int outstanding_width_p = 8
) (
  input logic                           clk_i,
  input logic                           reset_i,
  input logic                           up_i,
  input logic                           down_i,
  input logic [outstanding_width_p-1:0] outstanding_i
);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && (outstanding_i == {outstanding_width_p{1'b1}})))
    else $error("pending writer: outstanding counter overflow");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(down_i && (outstanding_i == {outstanding_width_p{1'b0}})))
    else $error("pending writer: outstanding counter underflow");

  a_up_down_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && down_i))
    else $error("pending writer: up and down asserted together");
endmodule

// File: tb/tb_bp_cce_hybrid_pending_writer.sv
// Scoreboard bench for bp_cce_hybrid_pending_writer: a queue-based reference model
// predicts each cycle's port response; a negedge monitor pops and compares.
module tb_bp_cce_hybrid_pending_writer;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  localparam int OW    = 8;

  typedef struct {
    logic         wv, up, down, byp, inc_rdy, dec_rdy, idle;
    logic [W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_cce_hybrid_pending_writer_if #(.paddr_width_p(W)) bus ();

  bp_cce_hybrid_pending_writer #(
    .paddr_width_p(W), .dec_fifo_els_p(DEPTH),
    .starve_limit_p(LIMIT), .outstanding_width_p(OW)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus.slave)
  );

  exp_t         exp_q[$];
  logic [W:0]   mq[$];
  int           starve, outst;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected record per driven cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("w_v", W'(bus.w_v_o), W'(e.wv));
      chk("up", W'(bus.up_o), W'(e.up));
      chk("down", W'(bus.down_o), W'(e.down));
      chk("clear", W'(bus.clear_o), W'(1'b0));
      chk("inc_ready", W'(bus.inc_ready_and_o), W'(e.inc_rdy));
      chk("dec_ready", W'(bus.dec_ready_and_o), W'(e.dec_rdy));
      chk("idle", W'(bus.idle_o), W'(e.idle));
      if (e.wv) begin
        chk("w_addr", bus.w_addr_o, e.addr);
        chk("w_bypass", W'(bus.w_addr_bypass_hash_o), W'(e.byp));
      end
    end
  end

  // Called at posedge+1: drive, predict, then advance one cycle
  task automatic do_cycle(input logic iv, input logic [W-1:0] ia, input logic ib,
                          input logic dv, input logic [W-1:0] da, input logic db,
                          output logic inc_acc, output logic dec_acc);
    exp_t       e;
    logic [W:0] h;
    logic       cancel;
    bus.inc_v_i = iv; bus.inc_addr_i = ia; bus.inc_bypass_i = ib;
    bus.dec_v_i = dv; bus.dec_addr_i = da; bus.dec_bypass_i = db;
    e.idle = (outst == 0) && (mq.size() == 0);
    e.dec_rdy = (mq.size() < DEPTH);
    e.wv = 1'b0; e.up = 1'b0; e.down = 1'b0; e.inc_rdy = 1'b0; e.addr = '0; e.byp = 1'b0;
    cancel = 1'b0;
`ifdef BP_CCE_HYBRID_PENDING_CANCEL_EN
    cancel = iv && (mq.size() > 0) && ({ia, ib} == mq[0]);
`endif
    if (cancel) begin
      e.inc_rdy = 1'b1;
      h = mq.pop_front();
    end else if ((iv && starve == LIMIT) || (iv && mq.size() == 0)) begin
      e.wv = 1'b1; e.up = 1'b1; e.inc_rdy = 1'b1; e.addr = ia; e.byp = ib;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e.wv = 1'b1; e.down = 1'b1; e.addr = h[W:1]; e.byp = h[0];
    end
    if (e.inc_rdy) starve = 0;
    else if (iv) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    if (dv && e.dec_rdy) mq.push_back({da, db});
    outst = (outst + int'(e.up) - int'(e.down)) & ((1 << OW) - 1);
    exp_q.push_back(e);
    inc_acc = e.inc_rdy;
    dec_acc = dv && e.dec_rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, a, b);
  endtask

  task automatic hold_inc(input logic [W-1:0] ia, input logic ib);
    logic a, b;
    int   n = 0;
    do begin
      do_cycle(1'b1, ia, ib, 1'b0, '0, 1'b0, a, b);
      n++;
    end while (!a && n < 20);
    if (!a) begin
      tests++; fails++;
      $display("FAIL inc_accept_timeout: got not-accepted expected accepted within 20 cycles");
    end
  endtask

  task automatic hold_dec(input logic [W-1:0] da, input logic db);
    logic a, b;
    int   n = 0;
    do begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, da, db, a, b);
      n++;
    end while (!b && n < 20);
    if (!b) begin
      tests++; fails++;
      $display("FAIL dec_accept_timeout: got not-accepted expected accepted within 20 cycles");
    end
  endtask

  task automatic do_reset();
    bus.inc_v_i = 1'b0; bus.inc_addr_i = '0; bus.inc_bypass_i = 1'b0;
    bus.dec_v_i = 1'b0; bus.dec_addr_i = '0; bus.dec_bypass_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #3;
    chk("rst_w_v", W'(bus.w_v_o), W'(1'b0));
    chk("rst_up", W'(bus.up_o), W'(1'b0));
    chk("rst_down", W'(bus.down_o), W'(1'b0));
    chk("rst_inc_ready", W'(bus.inc_ready_and_o), W'(1'b0));
    chk("rst_dec_ready", W'(bus.dec_ready_and_o), W'(1'b1));
    chk("rst_idle", W'(bus.idle_o), W'(1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    starve = 0;
    outst = 0;
  endtask

  initial begin
    logic a, b, iv, dv;
    int   bal;
    do_reset();
    idle_cycles(5);

    // single increment, later its decrement, then idle again
    hold_inc(32'h0000_1000, 1'b0);
    idle_cycles(1);
    hold_dec(32'h0000_1000, 1'b0);
    idle_cycles(3);

    // back-to-back decrements in FIFO order
    for (int i = 0; i < 6; i++) hold_inc(32'h0000_0100 + 32'(i), 1'b1);
    for (int i = 0; i < 5; i++) hold_dec(32'h0000_0200 + 32'(i), 1'(i));
    idle_cycles(4);

    // increment starved by a continuously refilled FIFO
    for (int i = 0; i < 8; i++) hold_inc(32'h0000_0300 + 32'(i), 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, a, b);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1, 32'h0000_0401 + 32'(i), 1'b0, a, b);
    end
    idle_cycles(10);

    // FIFO head and increment on the same address
    hold_inc(32'h0000_0010, 1'b0);
    hold_dec(32'h0000_2000, 1'b0);
    hold_inc(32'h0000_2000, 1'b0);
    idle_cycles(4);

    // randomized traffic, never decrementing more than was incremented
    for (int i = 0; i < 1500; i++) begin
      bal = outst - mq.size();
      iv  = (outst < 100) && ($urandom_range(0, 1) == 1);
      dv  = (bal > 0) && ($urandom_range(0, 2) != 0);
      do_cycle(iv, $urandom & 32'h0000_00ff, 1'($urandom), dv,
               $urandom & 32'h0000_00ff, 1'($urandom), a, b);
    end

    // reset while traffic is pending, then verify everything was discarded
    do_reset();
    idle_cycles(5);
    hold_inc(32'h0000_0abc, 1'b1);
    hold_dec(32'h0000_0abc, 1'b1);
    idle_cycles(3);

    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
